t01_lcd_arbiter: RTL and testbench

- Shares the single 2x16 character LCD driver among NUM_REQ message producers, such as game logic, score, and debug.
- Accepts whole-screen messages (row1 and row2, 16 ASCII bytes each) over a per-requester valid/ready handshake.
- Latches the granted message into the registered row_1/row_2 buses that feed the LCD driver.
- Holds each message for a minimum display time, then re-arbitrates round-robin.

---
 rtl/t01_lcd_pkg.sv | 17 +
 rtl/t01_rr_picker.sv | 34 +++
 rtl/t01_lcd_arbiter.sv | 164 ++++++++++++++++
 tb/tb_t01_lcd_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/t01_lcd_pkg.sv
// Shared definitions for the LCD arbiter slice: row geometry, the blank
// row pattern and the arbiter state encoding.
package t01_lcd_pkg;

    localparam int ROW_W  = 128;
    localparam int CHAR_W = 8;

    // Sixteen ASCII spaces: what the LCD shows before any message is granted.
    localparam logic [ROW_W-1:0] BLANK_ROW = {16{8'h20}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/t01_rr_picker.sv
// Round-robin winner selection, purely combinational.
// Searches indices last+1, last+2, ... modulo NUM_REQ and returns the first
// set bit of req.
// Ports:
//   req    : request vector, one bit per requester
//   last   : index of the most recently served requester
//   winner : selected index (0 when nothing is requested)
//   any    : high when at least one request bit is set
module t01_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        any    = 1'b0;
        // Offset 1 first so the previous owner is considered last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                winner = IDX_W'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/t01_lcd_arbiter.sv
// Shares one 2x16 character LCD driver among NUM_REQ message producers.
// A granted requester's two 16-character rows are latched into row_1/row_2
// and held for at least HOLD_CYCLES clocks before the next round-robin
// arbitration.
//
// Handshake: requester i raises req_valid[i] with stable row data and keeps
// both until req_ready[i] pulses for one cycle; data is captured on the
// clock edge that closes the ready cycle, so later data changes are ignored.
//
// Ports:
//   clk, rst      : clock; synchronous active-low reset
//   req_valid     : per-requester message pending
//   req_row1/2    : packed rows, requester i at [i*128 +: 128], leftmost char in MSB byte
//   req_ready     : one-cycle accept pulse per requester
//   row_1, row_2  : displayed rows to the LCD driver
//   owner         : index of requester whose message is displayed
//   owner_valid   : a message has been displayed since reset
//   busy          : arbiter is in GRANT or HOLD
//   state_dbg     : current arbiter state, for observation only
//
// Build option: define T01_LCD_ARB_PREEMPT_EN to let requester 0 cut short
// another requester's hold time.
module t01_lcd_arbiter
    import t01_lcd_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 800_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ROW_W-1:0]   req_row1,
    input  logic [NUM_REQ*ROW_W-1:0]   req_row2,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [ROW_W-1:0]           row_1,
    output logic [ROW_W-1:0]           row_2,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       owner_valid,
    output logic                       busy,
    output state_t                     state_dbg
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    state_t           state_q, state_d;
    logic [OW-1:0]    grant_q, grant_d;
    logic [OW-1:0]    last_q, last_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic             owner_valid_q, owner_valid_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ROW_W-1:0] row_1_q, row_1_d;
    logic [ROW_W-1:0] row_2_q, row_2_d;

    logic [OW-1:0]    pick_idx;
    logic             pick_any;
    logic             grant_ok;

    t01_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OW)
    ) u_picker (
        .req     (req_valid),
        .last    (last_q),
        .winner  (pick_idx),
        .any     (pick_any)
    );

    // A grant only completes if the chosen requester is still valid; a
    // withdrawn request is a protocol violation and is simply dropped.
    assign grant_ok = (state_q == GRANT) && req_valid[grant_q];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        cnt_d         = cnt_q;
        row_1_d       = row_1_q;
        row_2_d       = row_2_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = GRANT;
                end
            end

            GRANT: begin
                if (grant_ok) begin
                    row_1_d       = req_row1[int'(grant_q)*ROW_W +: ROW_W];
                    row_2_d       = req_row2[int'(grant_q)*ROW_W +: ROW_W];
                    owner_d       = grant_q;
                    owner_valid_d = 1'b1;
                    last_d        = grant_q;
                    cnt_d         = CW'(HOLD_CYCLES - 1);
                    state_d       = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end

            HOLD: begin
`ifdef T01_LCD_ARB_PREEMPT_EN
                // Requester 0 is urgent: it abandons anyone else's hold.
                if ((owner_q != '0) && req_valid[0]) begin
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = GRANT;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
`else
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_q        <= OW'(NUM_REQ - 1);
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            cnt_q         <= '0;
            row_1_q       <= BLANK_ROW;
            row_2_q       <= BLANK_ROW;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            cnt_q         <= cnt_d;
            row_1_q       <= row_1_d;
            row_2_q       <= row_2_d;
        end
    end

    // Ready is decoded from the registered state and grant; it is masked
    // while reset is asserted so no acceptance is signalled in that cycle.
    assign req_ready   = (rst && grant_ok) ? (NUM_REQ'(1) << grant_q) : '0;
    assign row_1       = row_1_q;
    assign row_2       = row_2_q;
    assign owner       = owner_q;
    assign owner_valid = owner_valid_q;
    assign busy        = (state_q == GRANT) || (state_q == HOLD);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_t01_lcd_arbiter.sv
// Bench for t01_lcd_arbiter (NUM_REQ=4, HOLD_CYCLES=4): directed scenarios
// followed by randomized requester traffic, all checked every cycle against
// a transaction-level model of the arbiter.
module tb_t01_lcd_arbiter;
    import t01_lcd_pkg::*;

    localparam int N  = 4;
    localparam int H  = 4;
    localparam int OW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]       req_valid = '0;
    logic [N*ROW_W-1:0] req_row1  = '0;
    logic [N*ROW_W-1:0] req_row2  = '0;
    logic [N-1:0]       req_ready;
    logic [ROW_W-1:0]   row_1, row_2;
    logic [OW-1:0]      owner;
    logic               owner_valid, busy;
    state_t             state_dbg;

    t01_lcd_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(H)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_row1    (req_row1),
        .req_row2    (req_row2),
        .req_ready   (req_ready),
        .row_1       (row_1),
        .row_2       (row_2),
        .owner       (owner),
        .owner_valid (owner_valid),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // ---------------- reference model ----------------
    // m_gp   : requester chosen and awaiting its accept cycle (-1 = none)
    // m_hold : remaining cycles of the minimum display time
    int               m_gp, m_hold, m_last, m_owner;
    logic             m_ov;
    logic [ROW_W-1:0] m_r1, m_r2;
    logic [N-1:0]     exp_ready_last;
    logic [N-1:0]     obs_ready;
    logic [ROW_W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [ROW_W-1:0] got,
                            input logic [ROW_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [ROW_W-1:0] rnd_row();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        m_gp    = -1;
        m_hold  = 0;
        m_last  = N - 1;
        m_owner = 0;
        m_ov    = 1'b0;
        m_r1    = BLANK_ROW;
        m_r2    = BLANK_ROW;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        logic [N-1:0] er;
        er = '0;
        if (rst && m_gp >= 0 && req_valid[m_gp]) er[m_gp] = 1'b1;
        exp_ready_last = er;
        check_eq("req_ready", ROW_W'(req_ready), ROW_W'(er));
        check_eq("row_1", row_1, m_r1);
        check_eq("row_2", row_2, m_r2);
        check_eq("owner", ROW_W'(owner), ROW_W'(m_owner));
        check_eq("owner_valid", ROW_W'(owner_valid), ROW_W'(m_ov));
        check_eq("busy", ROW_W'(busy), ROW_W'((m_gp >= 0) || (m_hold > 0)));
        if (exp_q.size() > 0) check_eq("accepted_row", row_1, exp_q.pop_front());
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_next();
        if (!rst) begin
            model_reset();
        end else if (m_gp >= 0) begin
            if (req_valid[m_gp]) begin
                m_r1    = req_row1[m_gp*ROW_W +: ROW_W];
                m_r2    = req_row2[m_gp*ROW_W +: ROW_W];
                m_owner = m_gp;
                m_ov    = 1'b1;
                m_last  = m_gp;
                m_hold  = H;
                exp_q.push_back(m_r1);
            end
            m_gp = -1;
        end else if (m_hold > 0) begin
`ifdef T01_LCD_ARB_PREEMPT_EN
            if (m_owner != 0 && req_valid[0]) begin
                m_gp   = 0;
                m_hold = 0;
            end else
`endif
            m_hold--;
        end else if (req_valid != '0) begin
            m_gp = rr_pick(req_valid, m_last);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are driven at the falling edge; outputs sampled 1 unit later.
    task automatic step();
        #1;
        obs_ready = req_ready;
        check_outputs();
        model_next();
        cyc++;
        @(negedge clk);
    endtask

    task automatic release_accepted();
        for (int i = 0; i < N; i++) begin
            if (exp_ready_last[i]) begin
                req_valid[i] = 1'b0;
                req_row1[i*ROW_W +: ROW_W] = rnd_row();
                req_row2[i*ROW_W +: ROW_W] = rnd_row();
            end
        end
    endtask

    task automatic run_release(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            release_accepted();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [ROW_W-1:0] score;
        int order[$];
        int pulse_cyc[$];
        int exp_order[7];

        exp_order      = '{0, 1, 2, 3, 0, 1, 3};
        score          = "SCORE 0042      ";
        exp_ready_last = '0;

        // reset held for three edges, then reset values checked
        rst = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        step();
        check_eq("reset_row_1_blank", row_1, {16{8'h20}});
        rst = 1'b1;

        // fairness: all pending, then 1010 once requester 0 served twice
        for (int i = 0; i < N; i++) begin
            req_row1[i*ROW_W +: ROW_W] = rnd_row();
            req_row2[i*ROW_W +: ROW_W] = rnd_row();
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 80 && order.size() < 7; k++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (obs_ready[i]) begin
                    order.push_back(i);
                    pulse_cyc.push_back(cyc);
                end
            end
            if (order.size() == 5) req_valid = 4'b1010;
        end
        check_eq("rr_grant_count", ROW_W'(order.size()), ROW_W'(7));
        for (int k = 0; k < order.size(); k++) begin
            check_eq("rr_order", ROW_W'(order[k]), ROW_W'(exp_order[k]));
            if (k > 0) check_eq("rr_spacing", ROW_W'(pulse_cyc[k] - pulse_cyc[k-1]), ROW_W'(H + 2));
        end
        req_valid = '0;
        run_release(8);

        // single request from requester 2
        req_row1[2*ROW_W +: ROW_W] = score;
        req_valid = 4'b0100;
        step();
        step();
        check_eq("single_ready", ROW_W'(obs_ready), ROW_W'(4'b0100));
        req_valid = '0;
        step();
        check_eq("single_row_1", row_1, score);
        check_eq("single_owner", ROW_W'(owner), ROW_W'(2));
        run_release(6);

        // protocol violation: requester 1 withdraws during its grant cycle
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        run_release(3);

        // reset in the second hold cycle
        req_valid = 4'b0100;
        step();
        step();
        req_valid = '0;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_eq("midreset_owner_valid", ROW_W'(owner_valid), ROW_W'(0));
        req_valid = 4'b1111;
        step();
        step();
        check_eq("midreset_first_grant", ROW_W'(obs_ready), ROW_W'(4'b0001));
        release_accepted();
        req_valid = '0;
        run_release(8);

        // requester 0 arrives while requester 1 holds the display
        req_valid = 4'b0010;
        step();
        step();
        release_accepted();
        step();
        req_valid[0] = 1'b1;
        run_release(10);

        // randomized traffic with occasional withdrawals and resets
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < N; i++) begin
                if (exp_ready_last[i]) begin
                    req_valid[i] = 1'b0;
                    req_row1[i*ROW_W +: ROW_W] = rnd_row();
                    req_row2[i*ROW_W +: ROW_W] = rnd_row();
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_valid[i] = 1'b1;
                        req_row1[i*ROW_W +: ROW_W] = rnd_row();
                        req_row2[i*ROW_W +: ROW_W] = rnd_row();
                    end
                end else if ($urandom_range(0, 99) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            step();
        end

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
